// File: rtl/minicpu_fetch_seq_pkg.sv
// Shared MiniCPU constants for the fetch sequencer: PCU operation encodings,
// default prefix opcodes and the sequencer state type.
package minicpu_fetch_seq_pkg;

  localparam logic [1:0] pIP_Out    = 2'd0;
  localparam logic [1:0] pIP_Plus_1 = 2'd1;
  localparam logic [1:0] pOp_Hold   = 2'd0;
  localparam logic [1:0] pOp_In     = 2'd1;

  localparam logic [3:0]  pPFX_DEF    = 4'h2;
  localparam logic [3:0]  pNFX_DEF    = 4'h6;
  localparam int unsigned pMaxPfx_DEF = 3;

  typedef enum logic {
    ST_IDLE,
    ST_FETCH
  } fetch_state_e;

  function automatic logic is_prefix(input logic [3:0] opc,
                                     input logic [3:0] pfx_opc,
                                     input logic [3:0] nfx_opc);
    return (opc == pfx_opc) || (opc == nfx_opc);
  endfunction

endpackage

// File: rtl/minicpu_fetch_seq_if.sv
// Fetch sequencer bus: EU handshake, SPI instruction memory and PCU controls.
// The sequencer uses the master modport; the EU/PCU/memory side uses slave.
interface minicpu_fetch_seq_if;

  logic       Fetch;
  logic       MISO;
  logic       nCS;
  logic       SCK;
  logic       Busy;
  logic       Done;
  logic [3:0] Opc;
  logic       Err;
  logic       IP_En;
  logic [1:0] IP_Op;
  logic       Op_En;
  logic [1:0] Op_Op;
  logic       PCU_Inc;
  logic       Op_Inv;
  logic       PCU_DI;

  modport master (
    input  Fetch, MISO,
    output nCS, SCK, Busy, Done, Opc, Err,
           IP_En, IP_Op, Op_En, Op_Op, PCU_Inc, Op_Inv, PCU_DI
  );

  modport slave (
    output Fetch, MISO,
    input  nCS, SCK, Busy, Done, Opc, Err,
           IP_En, IP_Op, Op_En, Op_Op, PCU_Inc, Op_Inv, PCU_DI
  );

endinterface

// File: rtl/minicpu_fetch_seq.sv
// MiniCPU instruction fetch sequencer: 16-clock SPI fetch windows, opcode
// capture, operand nibble shifting into the PCU and PFX/NFX chain refetch.
module minicpu_fetch_seq
  import minicpu_fetch_seq_pkg::*;
#(
  parameter logic [3:0]  pPFX    = pPFX_DEF,
  parameter logic [3:0]  pNFX    = pNFX_DEF,
  parameter int unsigned pMaxPfx = pMaxPfx_DEF
) (
  input logic                 Clk,
  input logic                 Rst,
  minicpu_fetch_seq_if.master bus
);

  localparam int unsigned      PFX_W     = (pMaxPfx < 1) ? 1 : $clog2(pMaxPfx + 1);
  localparam logic [PFX_W-1:0] PFX_LIMIT = PFX_W'(pMaxPfx);

  fetch_state_e     state, state_nxt;
  logic [3:0]       k, k_nxt;
  logic [PFX_W-1:0] pfx, pfx_nxt;
  logic [3:0]       opc_sr, opc_sr_nxt;
  logic [3:0]       opc_q, opc_nxt;
  logic             done_q, done_nxt;
  logic             err_q, err_nxt;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state  <= ST_IDLE;
      k      <= '0;
      pfx    <= '0;
      opc_sr <= '0;
      opc_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      k      <= k_nxt;
      pfx    <= pfx_nxt;
      opc_sr <= opc_sr_nxt;
      opc_q  <= opc_nxt;
      done_q <= done_nxt;
      err_q  <= err_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    k_nxt      = k;
    pfx_nxt    = pfx;
    opc_sr_nxt = opc_sr;
    opc_nxt    = opc_q;
    done_nxt   = 1'b0;
    err_nxt    = err_q;

    bus.nCS     = 1'b1;
    bus.SCK     = 1'b0;
    bus.Busy    = 1'b0;
    bus.IP_En   = 1'b0;
    bus.IP_Op   = pIP_Out;
    bus.Op_En   = 1'b0;
    bus.Op_Op   = pOp_Hold;
    bus.PCU_Inc = 1'b0;
    bus.Op_Inv  = 1'b0;
    bus.PCU_DI  = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (bus.Fetch) begin
          state_nxt = ST_FETCH;
          k_nxt     = '0;
          pfx_nxt   = '0;
          err_nxt   = 1'b0;
        end
      end

      ST_FETCH: begin
        bus.nCS     = 1'b0;
        bus.SCK     = k[0];
        bus.Busy    = 1'b1;
        bus.IP_En   = 1'b1;
        bus.IP_Op   = pIP_Plus_1;
        bus.Op_Op   = pOp_In;
        bus.PCU_Inc = (k == 4'd0);

        // Even k in the first half carries opcode bits, second half operand bits.
        if (!k[0] && !k[3]) begin
          opc_sr_nxt = {opc_sr[2:0], bus.MISO};
        end
        if (!k[0] && k[3]) begin
          bus.Op_En  = 1'b1;
          bus.PCU_DI = bus.MISO;
        end
        bus.Op_Inv = (k == 4'd14) && (opc_sr == pNFX);

        // k wraps 15 -> 0, so a prefix refetch simply stays in FETCH.
        k_nxt = k + 4'd1;
        if (k == 4'd15) begin
          if (is_prefix(opc_sr, pPFX, pNFX)) begin
            if (pfx < PFX_LIMIT) begin
              pfx_nxt = pfx + PFX_W'(1);
            end else begin
              state_nxt = ST_IDLE;
              pfx_nxt   = '0;
              err_nxt   = 1'b1;
              done_nxt  = 1'b1;
            end
          end else begin
            state_nxt = ST_IDLE;
            pfx_nxt   = '0;
            opc_nxt   = opc_sr;
            done_nxt  = 1'b1;
          end
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.Done = done_q;
  assign bus.Opc  = opc_q;
  assign bus.Err  = err_q;

endmodule

// File: tb/tb_minicpu_fetch_seq.sv
// Self-checking bench for minicpu_fetch_seq: transaction-level reference model
// checked every cycle, directed scenarios with literal expectations, random phase.
module tb_minicpu_fetch_seq;
  import minicpu_fetch_seq_pkg::*;

  localparam logic [3:0] PFX  = 4'h2;
  localparam logic [3:0] NFX  = 4'h6;
  localparam int         MAXP = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  minicpu_fetch_seq_if bus();

  minicpu_fetch_seq #(
    .pPFX   (PFX),
    .pNFX   (NFX),
    .pMaxPfx(MAXP)
  ) dut (
    .Clk(clk),
    .Rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [7:0] mem [256];

  // Reference model: one planned transaction at a time.
  bit         m_active = 1'b0;
  int         m_start  = 0;
  int         m_w      = 0;
  int         m_addr   = 0;
  bit         m_err    = 1'b0;
  logic [3:0] m_opc    = '0;
  int         fetch_addr = 0;
  bit         exp_done = 1'b0;
  bit         exp_err  = 1'b0;
  logic [3:0] exp_opc  = '0;

  // Observers of the PCU side, for literal checks.
  logic [15:0] op16     = '0;
  int          inc_cnt  = 0;
  int          done_cnt = 0;
  int          ncs_low  = 0;

  function automatic bit is_pfx(input logic [3:0] o);
    return (o == PFX) || (o == NFX);
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic plan();
    int n;
    logic [3:0] last;
    m_addr = fetch_addr;
    n = 0;
    while (n < MAXP && is_pfx(mem[8'(m_addr + n)][7:4])) n++;
    last     = mem[8'(m_addr + n)][7:4];
    m_w      = n + 1;
    m_err    = is_pfx(last);
    m_opc    = last;
    m_start  = cyc;
    m_active = 1'b1;
    exp_err  = 1'b0;
  endtask

  // Model update at the edge, MISO drive at +1, compare at +2.
  initial begin
    int o, k, w;
    logic [7:0] b;
    logic e_ncs, e_busy, e_sck, e_ipen, e_inc, e_open, e_inv, e_di;
    logic [1:0] e_ipop, e_opop;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_active = 1'b0;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        exp_opc  = '0;
      end else begin
        exp_done = 1'b0;
        if (m_active && cyc == m_start + 16 * m_w) begin
          m_active = 1'b0;
          exp_done = 1'b1;
          if (m_err) exp_err = 1'b1;
          else       exp_opc = m_opc;
          fetch_addr = (m_addr + m_w) % 256;
        end else if (!m_active && bus.Fetch) begin
          plan();
        end
      end

      o = 0; k = 0; w = 0; b = '0;
      if (m_active) begin
        o = cyc - m_start;
        k = o % 16;
        w = o / 16;
        b = mem[8'(m_addr + w)];
      end
      #1;
      if (m_active && (k % 2 == 0)) bus.MISO = b[3'(7 - k / 2)];
      else                          bus.MISO = 1'($urandom_range(0, 1));
      #1;

      e_ncs = 1'b1; e_busy = 1'b0; e_sck = 1'b0; e_ipen = 1'b0; e_inc = 1'b0;
      e_open = 1'b0; e_inv = 1'b0; e_di = 1'b0; e_ipop = pIP_Out; e_opop = pOp_Hold;
      if (m_active) begin
        e_ncs  = 1'b0;
        e_busy = 1'b1;
        e_sck  = 1'(k % 2);
        e_ipen = 1'b1;
        e_ipop = pIP_Plus_1;
        e_opop = pOp_In;
        e_inc  = (k == 0);
        e_open = (k >= 8) && (k % 2 == 0);
        e_inv  = (k == 14) && (b[7:4] == NFX);
        e_di   = e_open ? b[3'(7 - k / 2)] : 1'b0;
      end
      check("nCS",     16'(bus.nCS),     16'(e_ncs));
      check("Busy",    16'(bus.Busy),    16'(e_busy));
      check("SCK",     16'(bus.SCK),     16'(e_sck));
      check("IP_En",   16'(bus.IP_En),   16'(e_ipen));
      check("IP_Op",   16'(bus.IP_Op),   16'(e_ipop));
      check("PCU_Inc", 16'(bus.PCU_Inc), 16'(e_inc));
      check("Op_En",   16'(bus.Op_En),   16'(e_open));
      check("Op_Op",   16'(bus.Op_Op),   16'(e_opop));
      check("Op_Inv",  16'(bus.Op_Inv),  16'(e_inv));
      check("PCU_DI",  16'(bus.PCU_DI),  16'(e_di));
      check("Done",    16'(bus.Done),    16'(exp_done));
      check("Opc",     16'(bus.Opc),     16'(exp_opc));
      check("Err",     16'(bus.Err),     16'(exp_err));

      if (bus.Op_En)   op16 = {op16[14:0], bus.PCU_DI};
      if (bus.Op_Inv)  op16 = ~op16;
      if (bus.PCU_Inc) inc_cnt++;
      if (bus.Done)    done_cnt++;
      if (!bus.nCS)    ncs_low++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns the cycle in which Done is high, or -1 after a failed bound.
  task automatic wait_done(input int unsigned budget, output int dcyc);
    for (int unsigned i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.Done) begin
        dcyc = cyc;
        return;
      end
    end
    dcyc = -1;
    tests++;
    fails++;
    $display("FAIL done_timeout: got no Done within %0d cycles (cycle %0d)", budget, cyc);
  endtask

  // Pulses Fetch for one cycle; e is the edge that samples it.
  task automatic start_fetch(input int addr, output int e);
    @(negedge clk);
    fetch_addr = addr;
    op16       = '0;
    inc_cnt    = 0;
    ncs_low    = 0;
    bus.Fetch  = 1'b1;
    @(negedge clk);
    bus.Fetch  = 1'b0;
    e = cyc;
  endtask

  initial begin
    int e, d, d2, dc0;
    bus.Fetch = 1'b0;
    bus.MISO  = 1'b0;
    for (int unsigned i = 0; i < 256; i++) begin
      int unsigned r;
      r = $urandom_range(0, 5);
      mem[i][7:4] = (r < 2) ? PFX : (r == 2) ? NFX : 4'($urandom_range(0, 15));
      mem[i][3:0] = 4'($urandom_range(0, 15));
    end
    mem[16] = 8'h45;
    mem[32] = 8'h6F; mem[33] = 8'h25; mem[34] = 8'h60; mem[35] = 8'h13;
    mem[48] = 8'h21; mem[49] = 8'h22; mem[50] = 8'h23; mem[51] = 8'h24; mem[52] = 8'h70;
    mem[64] = 8'h9A;
    mem[80] = 8'hB5;
    mem[96] = 8'hC1; mem[97] = 8'hD2;

    tick(3);
    check("rst_nCS",  16'(bus.nCS),  16'd1);
    check("rst_Busy", 16'(bus.Busy), 16'd0);
    check("rst_Opc",  16'(bus.Opc),  16'd0);
    check("rst_Err",  16'(bus.Err),  16'd0);
    rst = 1'b0;
    tick(2);

    // Single byte 0x45: Done sampled at edge E+17 (high in the cycle after E+16).
    start_fetch(16, e);
    wait_done(100, d);
    check("t1_latency", 16'(d + 1 - e), 16'd17);
    check("t1_opc",     16'(bus.Opc),   16'h4);
    check("t1_op",      op16,           16'h0005);
    check("t1_ip_inc",  16'(inc_cnt),   16'd1);
    check("t1_err",     16'(bus.Err),   16'd0);

    // NFX F, PFX 5, NFX 0, 0x13 chain in a single fetch.
    start_fetch(32, e);
    wait_done(200, d);
    check("t2_latency", 16'(d + 1 - e), 16'd65);
    check("t2_ncs_low", 16'(ncs_low),   16'd64);
    check("t2_opc",     16'(bus.Opc),   16'h1);
    check("t2_op",      op16,           16'hFAF3);
    check("t2_ip_inc",  16'(inc_cnt),   16'd4);

    // Four prefixes overflow; the next accepted Fetch clears Err.
    start_fetch(48, e);
    wait_done(200, d);
    check("t3_latency", 16'(d + 1 - e), 16'd65);
    check("t3_err",     16'(bus.Err),   16'd1);
    check("t3_opc",     16'(bus.Opc),   16'h1);
    start_fetch(52, e);
    check("t3_err_clr", 16'(bus.Err),   16'd0);
    wait_done(100, d);
    check("t3_opc2",    16'(bus.Opc),   16'h7);

    // Fetch pulsed at k=5 while busy is ignored.
    start_fetch(64, e);
    dc0 = done_cnt;
    tick(5);
    bus.Fetch = 1'b1;
    tick(1);
    bus.Fetch = 1'b0;
    tick(45);
    check("t4_one_done", 16'(done_cnt - dc0), 16'd1);
    check("t4_opc",      16'(bus.Opc),        16'h9);

    // Reset at k=9 aborts without Done; a fresh fetch completes normally.
    start_fetch(80, e);
    tick(9);
    rst = 1'b1;
    #1;
    check("t5_nCS",  16'(bus.nCS),  16'd1);
    check("t5_Busy", 16'(bus.Busy), 16'd0);
    dc0 = done_cnt;
    @(negedge clk);
    rst = 1'b0;
    tick(20);
    check("t5_no_done", 16'(done_cnt - dc0), 16'd0);
    start_fetch(80, e);
    wait_done(100, d);
    check("t5_latency", 16'(d + 1 - e), 16'd17);
    check("t5_opc",     16'(bus.Opc),   16'hB);

    // Fetch held high: second window starts the clock after Done.
    @(negedge clk);
    fetch_addr = 96;
    bus.Fetch  = 1'b1;
    wait_done(100, d);
    wait_done(100, d2);
    bus.Fetch  = 1'b0;
    check("t6_spacing", 16'(d2 - d),  16'd17);
    check("t6_opc",     16'(bus.Opc), 16'hD);
    tick(5);

    // Random traffic: fetch pulses (also while busy) and rare resets.
    for (int unsigned i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (!m_active) fetch_addr = 128 + int'($urandom_range(0, 120));
      bus.Fetch = ($urandom_range(0, 4) == 0);
      rst       = ($urandom_range(0, 399) == 0);
    end
    @(negedge clk);
    bus.Fetch = 1'b0;
    rst       = 1'b0;
    tick(80);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
